lfsr_gen: RTL and testbench



---
 rtl/lfsr_gen.sv | 99 +++++++++
 tb/tb_lfsr_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Loadable, parametrised LFSR with wrap detection, step counter and zero-seed lockup guard.
// Define LFSR_GALOIS_EN to build the Galois (shift-right) form instead of Fibonacci.
module lfsr_gen #(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0]   SEED  = 8'h01,
  parameter int                 STEPS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] lfsr,
  output logic             wrap,
  output logic [WIDTH-1:0] period_cnt,
  output logic             lockup
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be in 3..32");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_gen: STEPS must be in 1..WIDTH");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be nonzero");
  end

  logic [WIDTH-1:0] ref_seed;
  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] ref_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;
  logic             lock_nxt;

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] s);
`ifdef LFSR_GALOIS_EN
    step1 = (s >> 1) ^ (s[0] ? TAPS : '0);
`else
    step1 = {s[WIDTH-2:0], ^(s & TAPS)};
`endif
  endfunction

  // STEPS single steps chained combinationally
  always_comb begin
    adv = lfsr;
    for (int i = 0; i < STEPS; i++) begin
      adv = step1(adv);
    end
  end

  always_comb begin
    lfsr_nxt = lfsr;
    ref_nxt  = ref_seed;
    cnt_nxt  = period_cnt;
    wrap_nxt = 1'b0;
    lock_nxt = lockup;
    if (load) begin
      lfsr_nxt = (seed_in != '0) ? seed_in : SEED;
      ref_nxt  = (seed_in != '0) ? seed_in : SEED;
      cnt_nxt  = '0;
      lock_nxt = (seed_in == '0);
    end else if (enable) begin
      if (lfsr == '0) begin
        // stuck state can only come from a fault; recover to the seed
        lfsr_nxt = SEED;
        ref_nxt  = SEED;
        cnt_nxt  = '0;
        lock_nxt = 1'b1;
      end else if (adv == ref_seed) begin
        lfsr_nxt = adv;
        cnt_nxt  = '0;
        wrap_nxt = 1'b1;
      end else begin
        lfsr_nxt = adv;
        cnt_nxt  = period_cnt + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr       <= SEED;
      ref_seed   <= SEED;
      period_cnt <= '0;
      wrap       <= 1'b0;
      lockup     <= 1'b0;
    end else begin
      lfsr       <= lfsr_nxt;
      ref_seed   <= ref_nxt;
      period_cnt <= cnt_nxt;
      wrap       <= wrap_nxt;
      lockup     <= lock_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: directed sequences plus random stimulus against an arithmetic model.
// Two instances share stimulus: STEPS=1 (u0) and STEPS=2 (u1).
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       reset, enable, load;
  logic [7:0] seed_in;
  logic [7:0] lfsr0, lfsr1, cnt0, cnt1;
  logic       wrap0, wrap1, lock0, lock1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
    .lfsr(lfsr0), .wrap(wrap0), .period_cnt(cnt0), .lockup(lock0));

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(2)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
    .lfsr(lfsr1), .wrap(wrap1), .period_cnt(cnt1), .lockup(lock1));

  // reference model state, index = instance (steps = index + 1)
  int m_lfsr [2];
  int m_ref  [2];
  int m_cnt  [2];
  int m_wrap [2];
  int m_lock [2];

  function automatic int ref_step(input int s);
    int fb;
`ifdef LFSR_GALOIS_EN
    if (s % 2 == 1) return (s / 2) ^ 'hB8;
    return s / 2;
`else
    fb = $countones(s & 'hB8) % 2;
    return (s * 2) % 256 + fb;
`endif
  endfunction

  function automatic void model_tick();
    int v;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_lfsr[k] = 1; m_ref[k] = 1; m_cnt[k] = 0; m_wrap[k] = 0; m_lock[k] = 0;
      end else if (load) begin
        m_wrap[k] = 0; m_cnt[k] = 0;
        if (seed_in != 0) begin
          m_lfsr[k] = seed_in; m_ref[k] = seed_in; m_lock[k] = 0;
        end else begin
          m_lfsr[k] = 1; m_ref[k] = 1; m_lock[k] = 1;
        end
      end else if (enable) begin
        v = m_lfsr[k];
        for (int s = 0; s <= k; s++) v = ref_step(v);
        m_lfsr[k] = v;
        if (v == m_ref[k]) begin
          m_wrap[k] = 1; m_cnt[k] = 0;
        end else begin
          m_wrap[k] = 0; m_cnt[k] = (m_cnt[k] + 1) % 256;
        end
      end else begin
        m_wrap[k] = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("u0.lfsr", {24'd0, lfsr0}, m_lfsr[0]);
    chk("u0.wrap", {31'd0, wrap0}, m_wrap[0]);
    chk("u0.cnt",  {24'd0, cnt0},  m_cnt[0]);
    chk("u0.lock", {31'd0, lock0}, m_lock[0]);
    chk("u1.lfsr", {24'd0, lfsr1}, m_lfsr[1]);
    chk("u1.wrap", {31'd0, wrap1}, m_wrap[1]);
    chk("u1.cnt",  {24'd0, cnt1},  m_cnt[1]);
    chk("u1.lock", {31'd0, lock1}, m_lock[1]);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_tick();
    check_model();
  endtask

`ifdef LFSR_GALOIS_EN
  logic [7:0] exp0 [4] = '{8'hB8, 8'h5C, 8'h2E, 8'h17};
  logic [7:0] exp1 [4] = '{8'h5C, 8'h17, 8'hE1, 8'h64};
`else
  logic [7:0] exp0 [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
  logic [7:0] exp1 [4] = '{8'h04, 8'h11, 8'h47, 8'h1C};
`endif

  int seen [256];
  int seen_cnt, wraps0, wrap_at0, wrap_at1;

  initial begin
    reset = 1'b1; enable = 1'b1; load = 1'b0; seed_in = 8'h00;
    foreach (m_lfsr[k]) begin
      m_lfsr[k] = 0; m_ref[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0; m_lock[k] = 0;
    end

    // reset for two cycles with enable held high, then the opening sequence
    cyc(); cyc();
    chk("rst.lfsr", {24'd0, lfsr0}, 32'h01);
    chk("rst.cnt",  {24'd0, cnt0},  32'h00);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("seq0[%0d]", i), {24'd0, lfsr0}, {24'd0, exp0[i]});
      chk($sformatf("seq1[%0d]", i), {24'd0, lfsr1}, {24'd0, exp1[i]});
    end

    // full period from the seed
    reset = 1'b1; cyc(); reset = 1'b0;
    foreach (seen[i]) seen[i] = 0;
    seen_cnt = 0; wraps0 = 0; wrap_at0 = 0; wrap_at1 = 0;
    for (int i = 1; i <= 255; i++) begin
      cyc();
      if (seen[lfsr0] == 0) seen_cnt++;
      seen[lfsr0]++;
      if (wrap0) begin wraps0++; wrap_at0 = i; end
      if (wrap1 && wrap_at1 == 0) wrap_at1 = i;
    end
    chk("period.wraps",   wraps0,   1);
    chk("period.wrap_at", wrap_at0, 255);
    chk("period.unique",  seen_cnt, 255);
    chk("period.zero",    seen[0],  0);
    chk("period.end",     {24'd0, lfsr0}, 32'h01);
    chk("period.cnt",     {24'd0, cnt0},  32'h00);
    chk("steps2.wrap_at", wrap_at1, 255);

    // load with simultaneous enable takes no step; wrap returns to the loaded seed
    load = 1'b1; seed_in = 8'h5A; enable = 1'b1;
    cyc();
    chk("load.lfsr0", {24'd0, lfsr0}, 32'h5A);
    chk("load.lfsr1", {24'd0, lfsr1}, 32'h5A);
    load = 1'b0;
    wrap_at0 = 0;
    for (int i = 1; i <= 255; i++) begin
      cyc();
      if (wrap0 && wrap_at0 == 0) begin
        wrap_at0 = i;
        chk("load.wrap_lfsr", {24'd0, lfsr0}, 32'h5A);
      end
    end
    chk("load.wrap_at", wrap_at0, 255);

    // zero seed rejected, lockup sticky until a nonzero load
    load = 1'b1; seed_in = 8'h00;
    cyc();
    chk("lock.lfsr", {24'd0, lfsr0}, 32'h01);
    chk("lock.set",  {31'd0, lock0}, 32'h1);
    load = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("lock.held", {31'd0, lock0}, 32'h1);
    load = 1'b1; seed_in = 8'h33;
    cyc();
    chk("lock.clr",  {31'd0, lock0}, 32'h0);
    chk("lock.lfsr33", {24'd0, lfsr0}, 32'h33);
    load = 1'b0;

    // reset mid-run
    for (int i = 0; i < 7; i++) cyc();
    reset = 1'b1; cyc();
    chk("midrst.lfsr", {24'd0, lfsr0}, 32'h01);
    reset = 1'b0;
    cyc();
    chk("midrst.next", {24'd0, lfsr0}, {24'd0, exp0[0]});

    // random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 99) < 2);
      load    = ($urandom_range(0, 99) < 6);
      enable  = ($urandom_range(0, 99) < 75);
      seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
